io_bridge: RTL
==============

# io_bridge

Host-side I/O bridge for the `fst` 16-bit core. It accepts the core's output-port writes (`out_en`/`out_dat`), buffers them in a small FIFO, and hands them to the host over a valid/ready stream. It also holds the value the core samples on `in_dat`, loaded from a host-side input stream. It reports when the core has halted and all buffered output has been delivered. It sits beside `imem`/`dmem` at the core's I/O pins.

## Interface

Parameters:
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2.
- `WIDTH`, 16, data width; matches core `out_dat`/`in_dat`.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low. 0 clears all state immediately.
- `out_en` in 1: core output write strobe, one word per cycle when high.
- `out_dat` in WIDTH: core output word, valid when `out_en`=1.
- `is_halt` in 1: core halted (level).
- `in_dat` out WIDTH: input word presented to the core.
- `tx_valid` out 1: host stream has a word.
- `tx_dat` out WIDTH: host stream word; equals FIFO head.
- `tx_ready` in 1: host accepts `tx_dat`.
- `rx_valid` in 1: host offers a new input word.
- `rx_dat` in WIDTH: host input word.
- `rx_ready` out 1: bridge accepts `rx_dat`.
- `count` out $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a core write was dropped.
- `drained` out 1: halted and FIFO empty.

## Operation

- FIFO state: storage array `DEPTH`×`WIDTH`, write pointer, read pointer (log2 DEPTH bits, wrap modulo DEPTH), occupancy counter.
- Push: `out_en`=1 and (`count`<DEPTH, or `count`=DEPTH with a pop in the same cycle). Writes `out_dat` at the write pointer, then advances the pointer.
- Pop: `tx_valid`=1 and `tx_ready`=1. Advances the read pointer.
- Occupancy update: `count` +1 on push only, −1 on pop only, unchanged on push+pop or on neither.
- Simultaneous push and pop at `count`=1: the push is accepted. The new word becomes the head the next cycle, and `tx_valid` stays 1.
- Overflow: `out_en`=1, `count`=DEPTH, no pop. The word is dropped, FIFO contents are unchanged, and `overflow` is set next edge. It is cleared only by reset. The core cannot be stalled, so drops are the defined behaviour.
- Output stream: `tx_valid` = (`count`≠0); `tx_dat` = storage[read pointer]. Both are derived from registered state only, with no combinational path from `out_en` or `tx_ready`.
- Input register: `rx_ready` is tied to 1. On `rx_valid`=1, `in_dat` loads `rx_dat` at the next edge and holds until the next `rx_valid`.
- `drained`: registered. Next value = `is_halt` & (`count`=0) & !`out_en`. Clears the cycle after `is_halt` drops or a word is pushed.

## Timing

- Reset values (`reset`=0, asynchronous): `count`=0, pointers=0, `tx_valid`=0, `overflow`=0, `drained`=0, `in_dat`=0, `rx_ready`=1. `tx_dat` is don't-care while `tx_valid`=0.
- Reset asserted mid-operation discards all buffered words at once; no partial pop is reported.
- Push-to-`tx_valid` latency is 1 cycle: a write at edge N is visible on `tx_dat` after edge N.
- Pop takes effect at the edge where `tx_valid`&`tx_ready`; the next head is visible after that edge.
- `rx` latency is 1 cycle: `rx_valid` at edge N makes the new `in_dat` visible after edge N.
- Throughput is one push and one pop per cycle sustained.
- Pointer wrap: index DEPTH−1 → 0, with no bubble.
- `drained` latency is 1 cycle after its conditions hold.

## Test plan

- Reset: hold `reset`=0 for 3 cycles while toggling `out_en`/`rx_valid` → `count`=0, `tx_valid`=0, `overflow`=0, `drained`=0, `in_dat`=0.
- Single word: `out_en`=1, `out_dat`=16'h1234 for one cycle, `tx_ready`=0 → next cycle `tx_valid`=1, `tx_dat`=16'h1234, `count`=1. Then `tx_ready`=1 for one cycle → `count`=0, `tx_valid`=0.
- Fill and overflow (DEPTH=8): `tx_ready`=0, push 1..9 → `count`=8, `overflow`=1. Then drain with `tx_ready`=1 → host receives 1..8 in order and 9 is absent.
- Full with simultaneous push and pop: fill with 1..8, then one cycle of `out_en`=1 (`out_dat`=16'hA) with `tx_ready`=1 → `overflow` stays 0, `count` stays 8. Drain yields 2..8 then 16'hA, exercising pointer wrap.
- Input path: `rx_valid`=1, `rx_dat`=16'h00FF for one cycle → `in_dat`=16'h00FF from the next cycle. It holds after `rx_valid`=0.
- Halt drain: 3 words buffered, `is_halt`=1, `tx_ready`=1 → `drained` rises 1 cycle after `count` reaches 0. Asserting `reset`=0 mid-drain instead → immediate `count`=0, `tx_valid`=0.

Source files
------------

// File: rtl/io_bridge.sv
// Host-side I/O bridge for the fst core: buffers core output words in a FIFO
// toward a valid/ready host stream and holds the core's input word.
module io_bridge #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     out_en,
    input  logic [WIDTH-1:0]         out_dat,
    input  logic                     is_halt,
    output logic [WIDTH-1:0]         in_dat,
    output logic                     tx_valid,
    output logic [WIDTH-1:0]         tx_dat,
    input  logic                     tx_ready,
    input  logic                     rx_valid,
    input  logic [WIDTH-1:0]         rx_dat,
    output logic                     rx_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     drained
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic             drained_reg, drained_next;
    logic [WIDTH-1:0] in_dat_reg, in_dat_next;
    logic             full, push, pop;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign full = (count_reg == FULL_CNT);
    assign pop  = (count_reg != '0) && tx_ready;
    assign push = out_en && (!full || pop);

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        in_dat_next   = in_dat_reg;
        drained_next  = is_halt && (count_reg == '0) && !out_en;

        if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;

        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        if (out_en && !push) overflow_next = 1'b1;
        if (rx_valid)        in_dat_next   = rx_dat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            drained_reg  <= 1'b0;
            in_dat_reg   <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            drained_reg  <= drained_next;
            in_dat_reg   <= in_dat_next;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= out_dat;
    end

    assign tx_valid = (count_reg != '0);
    assign tx_dat   = mem[rd_ptr_reg];
    assign rx_ready = 1'b1;
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign drained  = drained_reg;
    assign in_dat   = in_dat_reg;

endmodule
